// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver and upstream display logic.
// Patterns are active-low {dp,g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam int          DIG_W      = 2;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;
    localparam logic [3:0]  AN_OFF     = 4'hF;

    typedef logic [DIG_W-1:0] dig_t;

    // Hex nibble to active-low pattern, decimal point off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] pat;
        case (hex)
            4'h0: pat = 8'hC0;
            4'h1: pat = 8'hF9;
            4'h2: pat = 8'hA4;
            4'h3: pat = 8'hB0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hF8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'hA: pat = 8'h88;
            4'hB: pat = 8'h83;
            4'hC: pat = 8'hC6;
            4'hD: pat = 8'hA1;
            4'hE: pat = 8'h86;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter and digit index for the display scan; flags the last cycle of a frame.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int CW       = $clog2(SCAN_DIV)
) (
    input  logic          Clk100M,
    input  logic          reset,
    output logic [CW-1:0] cnt,
    output dig_t          dig,
    output logic          frame_tick
);

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam dig_t          DIG_LAST = dig_t'(NUM_DIGITS - 1);

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            cnt        <= '0;
            dig        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (cnt == CNT_LAST) && (dig == DIG_LAST);
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                dig <= dig + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with blank interval and 8-level brightness.
// Optional per-digit blinking when SEG_SCAN_BLINK_EN is defined.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic       Clk100M,
    input  logic       reset,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    input  logic [2:0] bright,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [3:0] blink_mask,
    input  logic       blink_phase,
`endif
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int          CW      = $clog2(SCAN_DIV);
    localparam logic [31:0] BLANK_L = 32'(BLANK_CYCLES);
    localparam logic [31:0] ON_STEP = 32'((SCAN_DIV - BLANK_CYCLES) / 8);

    logic [CW-1:0] cnt;
    dig_t          dig;
    logic          slot_start;
    logic [7:0]    seg_sel;
    logic [7:0]    seg_snap;
    logic [7:0]    seg_cur;
    logic [2:0]    bright_snap;
    logic [2:0]    bright_cur;
    logic [31:0]   on_lim;
    logic [31:0]   cnt_w;
    logic          lit;
    logic          blank_force;

    seg_scan_timer #(.SCAN_DIV(SCAN_DIV), .CW(CW)) u_timer (
        .Clk100M    (Clk100M),
        .reset      (reset),
        .cnt        (cnt),
        .dig        (dig),
        .frame_tick (frame_tick)
    );

    assign slot_start = (cnt == '0);

    always_comb begin
        seg_sel = SEG_BLANK;
        case (dig)
            2'd0: seg_sel = seg0;
            2'd1: seg_sel = seg1;
            2'd2: seg_sel = seg2;
            2'd3: seg_sel = seg3;
        endcase
    end

    // At cnt==0 the snapshot is being loaded, so use the inputs directly; keeps
    // BLANK_CYCLES==0 correct without an extra cycle of latency.
    assign seg_cur    = slot_start ? seg_sel : seg_snap;
    assign bright_cur = slot_start ? bright  : bright_snap;

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            seg_snap    <= SEG_BLANK;
            bright_snap <= '0;
        end else if (slot_start) begin
            seg_snap    <= seg_sel;
            bright_snap <= bright;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    logic       phase_meta;
    logic       phase_sync;
    logic [3:0] mask_snap;
    logic [3:0] mask_cur;

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            phase_meta <= 1'b0;
            phase_sync <= 1'b0;
            mask_snap  <= '0;
        end else begin
            phase_meta <= blink_phase;
            phase_sync <= phase_meta;
            if (slot_start) mask_snap <= blink_mask;
        end
    end

    assign mask_cur    = slot_start ? blink_mask : mask_snap;
    assign blank_force = mask_cur[dig] & phase_sync;
`else
    assign blank_force = 1'b0;
`endif

    assign cnt_w  = 32'(cnt);
    assign on_lim = BLANK_L + (32'(bright_cur) + 32'd1) * ON_STEP;
    assign lit    = (cnt_w >= BLANK_L) && (cnt_w < on_lim) && !blank_force;

    // an and seg always switch together so no segment is driven on a dark digit.
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else if (lit) begin
            seg <= seg_cur;
            an  <= ~(4'b0001 << dig);
        end else begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=16, BLANK_CYCLES=8).
// Define SEG_SCAN_BLINK_EN on both RTL and bench to cover the blink ports.
module tb_seg_scan_driver;
    localparam int SD = 16;
    localparam int BC = 8;
    localparam int STEP = (SD - BC) / 8;

    logic       Clk100M = 1'b0;
    logic       reset;
    logic [7:0] seg0, seg1, seg2, seg3;
    logic [2:0] bright;
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame_tick;
`ifdef SEG_SCAN_BLINK_EN
    logic [3:0] blink_mask;
    logic       blink_phase;
    logic [3:0] m_mask;
    logic       ph_hist [2];
`endif

    int errors = 0;
    int checks = 0;
    int pos;               // edges since reset release
    logic [7:0] m_seg;
    int         m_b;
    int         lit_cnt, ft_cnt, ft_at, tick_idx;
    int         dig_lit [4];

    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .Clk100M    (Clk100M),
        .reset      (reset),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .bright     (bright),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask (blink_mask),
        .blink_phase(blink_phase),
`endif
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 Clk100M = ~Clk100M;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pick(input int d);
        case (d)
            0: return seg0;
            1: return seg1;
            2: return seg2;
            default: return seg3;
        endcase
    endfunction

    // One clock: compute what the display must show for this edge, then compare.
    task automatic tick();
        logic [7:0] e_seg;
        logic [3:0] e_an;
        logic       e_ft;
        logic       on;
        int p, d;
        @(posedge Clk100M);
        e_seg = 8'hFF; e_an = 4'hF; e_ft = 1'b0; d = 0;
        if (reset) begin
            pos = 0;
`ifdef SEG_SCAN_BLINK_EN
            ph_hist[0] = 1'b0; ph_hist[1] = 1'b0;
`endif
        end else begin
            p = pos % SD;
            d = (pos / SD) % 4;
            if (p == 0) begin
                m_seg = pick(d);
                m_b   = int'(bright);
`ifdef SEG_SCAN_BLINK_EN
                m_mask = blink_mask;
`endif
            end
            on = (p >= BC) && (p < BC + (m_b + 1) * STEP);
`ifdef SEG_SCAN_BLINK_EN
            if (m_mask[d] && ph_hist[1]) on = 1'b0;
            ph_hist[1] = ph_hist[0];
            ph_hist[0] = blink_phase;
`endif
            if (on) begin
                e_seg = m_seg;
                e_an  = ~(4'b0001 << d);
            end
            e_ft = (p == SD - 1) && (d == 3);
            pos++;
        end
        #1;
        chk("an", {28'd0, an}, {28'd0, e_an});
        chk("seg", {24'd0, seg}, {24'd0, e_seg});
        chk("frame_tick", {31'd0, frame_tick}, {31'd0, e_ft});
        chk("an_onehot", {31'd0, (an == 4'hF) || $onehot(~an)}, 32'd1);
        if (an != 4'hF) begin
            lit_cnt++;
            for (int k = 0; k < 4; k++) if (!an[k]) dig_lit[k]++;
        end
        if (frame_tick) begin
            ft_cnt++;
            ft_at = tick_idx;
        end
        tick_idx++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        lit_cnt = 0; ft_cnt = 0; ft_at = -1; tick_idx = 0;
        for (int k = 0; k < 4; k++) dig_lit[k] = 0;
    endtask

    task automatic set_segs(input logic [7:0] a, b, c, e);
        seg0 = a; seg1 = b; seg2 = c; seg3 = e;
    endtask

    typedef struct {
        logic [2:0] b;
        logic [7:0] s0, s1, s2, s3;
        int         exp_lit;     // lit cycles in one 64-cycle frame
    } vec_t;
    vec_t tbl [5];

    initial begin
        tbl[0] = '{3'd7, 8'hC0, 8'hF9, 8'hA4, 8'hB0, 32};
        tbl[1] = '{3'd0, 8'hC0, 8'hF9, 8'hA4, 8'hB0, 4};
        tbl[2] = '{3'd3, 8'h99, 8'h92, 8'h82, 8'hF8, 16};
        tbl[3] = '{3'd5, 8'h00, 8'h7F, 8'h55, 8'hAA, 24};
        tbl[4] = '{3'd1, 8'h80, 8'h90, 8'h88, 8'h83, 8};

        pos = 0; m_seg = 8'hFF; m_b = 0;
        bright = 3'd7;
        set_segs(8'h00, 8'h00, 8'h00, 8'h00);
`ifdef SEG_SCAN_BLINK_EN
        blink_mask = 4'h0; blink_phase = 1'b0; m_mask = 4'h0;
        ph_hist[0] = 1'b0; ph_hist[1] = 1'b0;
`endif
        // reset held 3 cycles, then the first cycle after release stays blank
        do_reset(3);
        tick();
        chk("post_release_an", {28'd0, an}, 32'hF);

        foreach (tbl[i]) begin
            bright = tbl[i].b;
            set_segs(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3);
            do_reset(2);
            repeat (64) tick();
            chk($sformatf("tbl%0d_lit", i), lit_cnt, tbl[i].exp_lit);
            chk($sformatf("tbl%0d_ft_cnt", i), ft_cnt, 1);
            chk($sformatf("tbl%0d_ft_at", i), ft_at, 63);
        end

        // mid-slot input change only appears at the next digit-0 slot
        bright = 3'd7;
        set_segs(8'hC0, 8'hF9, 8'hA4, 8'hB0);
        do_reset(2);
        repeat (11) tick();
        seg0 = 8'h80;
        repeat (2) tick();
        chk("snap_hold_seg", {24'd0, seg}, 32'hC0);
        repeat (60) tick();
        chk("snap_next_seg", {24'd0, seg}, 32'h80);
        chk("snap_next_an", {28'd0, an}, 32'hE);

        // reset mid digit-2 slot, then restart at digit 0
        seg0 = 8'hC0;
        do_reset(2);
        repeat (44) tick();
        chk("pre_reset_an", {28'd0, an}, 32'hB);
        reset = 1'b1;
        tick();
        chk("mid_reset_an", {28'd0, an}, 32'hF);
        chk("mid_reset_seg", {24'd0, seg}, 32'hFF);
        do_reset(1);
        repeat (9) tick();
        chk("restart_an", {28'd0, an}, 32'hE);
        chk("restart_seg", {24'd0, seg}, 32'hC0);

`ifdef SEG_SCAN_BLINK_EN
        blink_mask = 4'b0010; blink_phase = 1'b1;
        do_reset(2);
        repeat (64) tick();
        chk("blink_d1_dark", dig_lit[1], 0);
        chk("blink_d0_lit", dig_lit[0], 8);
        chk("blink_d3_lit", dig_lit[3], 8);
        blink_mask = 4'h0; blink_phase = 1'b0;
`endif

        // randomized inputs against the reference model
        for (int n = 0; n < 800; n++) begin
            set_segs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            bright = 3'($urandom);
            reset  = ($urandom_range(0, 149) == 0);
`ifdef SEG_SCAN_BLINK_EN
            blink_mask  = 4'($urandom);
            blink_phase = ($urandom_range(0, 9) == 0) ? ~blink_phase : blink_phase;
`endif
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
